demux_fifo: RTL

- Buffers a single valid/ready stream tagged with a destination id and fans it out to NUM_DST valid/ready consumers.
- Mirrors the multi-source mux FIFO used elsewhere in the design: that block merges N sources into one stream; this block splits one stream into N sinks.
- Holds a shared in-order FIFO. Only the head entry is presented, to exactly one destination (head-of-line ordering preserved).

---
 rtl/demux_fifo.sv | 91 +++++++++
 1 files changed

// File: rtl/demux_fifo.sv
`default_nettype none
// ============================================================================
// Module      : demux_fifo
// Description : Shared in-order FIFO that fans one id-tagged valid/ready
//               stream out to NUM_DST valid/ready consumers.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DST    = 3,
  parameter int ID_WIDTH   = 2,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       soft_rst,
  input  logic                       src_vld,
  output logic                       src_rdy,
  input  logic [ID_WIDTH-1:0]        src_id,
  input  logic [DATA_WIDTH-1:0]      src_data,
  output logic [NUM_DST-1:0]         dst_vld,
  input  logic [NUM_DST-1:0]         dst_rdy,
  output logic [DATA_WIDTH-1:0]      dst_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]       c_PTR_ONE = (AW+1)'(1);
  localparam logic [ID_WIDTH:0] c_NUM_DST = (ID_WIDTH+1)'(NUM_DST);

  logic [ID_WIDTH-1:0]   r_mem_id   [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  r_drop_err;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_src_hsk;
  logic                  w_legal;
  logic                  w_push;
  logic                  w_pop;
  logic [ID_WIDTH-1:0]   w_head_id;

  // Extra wrap bit distinguishes full from empty when index bits match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign src_rdy   = ~w_full;
  assign w_src_hsk = src_vld & ~w_full;
  assign w_legal   = ({1'b0, src_id} < c_NUM_DST);
  assign w_push    = w_src_hsk & w_legal;
  assign w_head_id = r_mem_id[r_rd_ptr[AW-1:0]];
  assign w_pop     = |(dst_vld & dst_rdy);

  generate
    for (genvar g = 0; g < NUM_DST; g++) begin : g_dst
      assign dst_vld[g] = ~w_empty & (w_head_id == ID_WIDTH'(g));
    end
  endgenerate

  assign dst_data = w_empty ? '0 : r_mem_data[r_rd_ptr[AW-1:0]];
  assign count    = r_wr_ptr - r_rd_ptr;
  assign drop_err = r_drop_err;

  always_ff @(posedge clk) begin
    if (rst || soft_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_id[i]   <= '0;
        r_mem_data[i] <= '0;
      end
    end else begin
      // Illegal-id beats are consumed from the source but never stored.
      r_drop_err <= w_src_hsk & ~w_legal;
      if (w_push) begin
        r_mem_id[r_wr_ptr[AW-1:0]]   <= src_id;
        r_mem_data[r_wr_ptr[AW-1:0]] <= src_data;
        r_wr_ptr                     <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

endmodule
`default_nettype wire
